// File: rtl/nibble_sat_accum_pkg.sv
// Shared widths, lane clamp limits and FSM state type for the packed-nibble
// saturating accumulator.
package nibble_sat_accum_pkg;

    localparam int LANES = 4;
    localparam int LW    = 4;
    localparam int CNTW  = 4;

    localparam logic signed [LW-1:0] LANE_MAX = 4'sh7;
    localparam logic signed [LW-1:0] LANE_MIN = 4'sh8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_sat_accum_if.sv
// Operand beat stream into the accumulator: valid/ready with packed data and
// a per-beat add/subtract select.
interface nibble_sat_accum_if;
    import nibble_sat_accum_pkg::*;

    logic                  in_valid;
    logic [LANES*LW-1:0]   in_data;
    logic                  in_sub;
    logic                  in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_sub,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sub,
        output in_ready
    );

endinterface

// File: rtl/nibble_sat_lane.sv
// One signed lane: 5-bit add/subtract followed by clamp to the lane range.
module nibble_sat_lane
    import nibble_sat_accum_pkg::*;
(
    input  logic [LW-1:0] a,
    input  logic [LW-1:0] b,
    input  logic          sub,
    output logic [LW-1:0] r,
    output logic          sat
);

    logic [LW:0] a_ext;
    logic [LW:0] b_ext;
    logic [LW:0] sum;

    assign a_ext = {a[LW-1], a};
    assign b_ext = {b[LW-1], b};
    assign sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);

    // The extra bit disagreeing with the lane sign bit means the result left
    // the representable range; its top bit tells which end to clamp to.
    always_comb begin
        r   = sum[LW-1:0];
        sat = 1'b0;
        if (sum[LW] != sum[LW-1]) begin
            sat = 1'b1;
            r   = sum[LW] ? LANE_MIN : LANE_MAX;
        end
    end

endmodule

// File: rtl/nibble_sat_accum.sv
// Multi-beat lane-wise saturating accumulator: FSM, beat counter, packed
// accumulator and sticky per-lane saturation flags.
module nibble_sat_accum
    import nibble_sat_accum_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNTW-1:0]      len,
    input  logic                 abort,
    nibble_sat_accum_if.slave    beat,
    output logic                 busy,
    output logic                 done,
    output logic [LANES*LW-1:0]  acc_out,
    output logic [LANES-1:0]     sat_flags
);

    state_t                state_reg, state_next;
    logic [CNTW-1:0]       cnt_reg, cnt_next;
    logic [LANES*LW-1:0]   acc_reg, acc_next;
    logic [LANES-1:0]      sat_reg, sat_next;

    logic [LANES*LW-1:0]   lane_r;
    logic [LANES-1:0]      lane_sat;
    logic                  beat_fire;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            nibble_sat_lane u_lane (
                .a   (acc_reg[gi*LW +: LW]),
                .b   (beat.in_data[gi*LW +: LW]),
                .sub (beat.in_sub),
                .r   (lane_r[gi*LW +: LW]),
                .sat (lane_sat[gi])
            );
        end
    endgenerate

    // Status outputs depend on the state register alone.
    assign beat.in_ready = (state_reg == ACCUM);
    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign acc_out       = acc_reg;
    assign sat_flags     = sat_reg;

    assign beat_fire = beat.in_valid && beat.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            sat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            sat_reg   <= sat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        sat_next   = sat_reg;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    acc_next = '0;
                    sat_next = '0;
                    if (len != '0) begin
                        cnt_next   = len;
                        state_next = ACCUM;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            ACCUM: begin
                // Abort wins over a coincident beat, leaving results as they were.
                if (abort) begin
                    state_next = IDLE;
                end else if (beat_fire) begin
                    acc_next = lane_r;
                    sat_next = sat_reg | lane_sat;
                    cnt_next = cnt_reg - CNTW'(1);
                    if (cnt_reg == CNTW'(1)) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_sat_accum.sv
// Directed bench: stimulus pushes expected final results into a queue; a
// monitor pops and compares on every done pulse.
module tb_nibble_sat_accum;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] acc_out;
    logic [3:0]  sat_flags;

    nibble_sat_accum_if bus ();

    nibble_sat_accum dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .beat      (bus),
        .busy      (busy),
        .done      (done),
        .acc_out   (acc_out),
        .sat_flags (sat_flags)
    );

    typedef struct packed {
        logic [15:0] acc;
        logic [3:0]  sat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_err;
    int          done_count;
    logic [15:0] beat_d [16];
    logic        beat_s [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_count++;
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL done_unexpected: got done with acc_out=%04h sat_flags=%01h, expected no done",
                         acc_out, sat_flags);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({acc_out, sat_flags} !== {e.acc, e.sat}) begin
                    n_err++;
                    $display("FAIL result: got acc_out=%04h sat_flags=%01h, expected acc_out=%04h sat_flags=%01h",
                             acc_out, sat_flags, e.acc, e.sat);
                end else begin
                    $display("ok   result: acc_out=%04h sat_flags=%01h", acc_out, sat_flags);
                end
            end
        end
    end

    // Runs one reduction from beat_d/beat_s. With gaps set, an idle cycle
    // precedes each odd beat and start is held high there to prove it is ignored.
    task automatic run_reduction(input logic [3:0] l, input int nb, input bit gaps,
                                 input logic [15:0] ea, input logic [3:0] es,
                                 output int cycles);
        int n;
        sb_q.push_back({ea, es});
        start = 1'b1;
        len   = l;
        tick();
        start  = 1'b0;
        len    = 4'd0;
        cycles = 1;
        for (int i = 0; i < nb; i++) begin
            if (gaps && (i % 2 == 1)) begin
                bus.in_valid = 1'b0;
                start        = 1'b1;
                len          = 4'd1;
                tick();
                start  = 1'b0;
                len    = 4'd0;
                cycles++;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = beat_d[i];
            bus.in_sub   = beat_s[i];
            check($sformatf("in_ready_beat%0d", i), 32'(bus.in_ready), 32'd1);
            tick();
            cycles++;
        end
        bus.in_valid = 1'b0;
        bus.in_sub   = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            cycles++;
            n++;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int dc;
        n_vec        = 0;
        n_err        = 0;
        done_count   = 0;
        rst          = 1'b1;
        start        = 1'b1;
        len          = 4'd3;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        bus.in_sub   = 1'b0;

        // Reset held with start asserted.
        repeat (3) tick();
        check("rst_acc_out",   32'(acc_out),      32'h0);
        check("rst_sat_flags", 32'(sat_flags),    32'h0);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_in_ready",  32'(bus.in_ready), 32'd0);
        check("rst_done",      32'(done),         32'd0);
        start = 1'b0;
        len   = 4'd0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("idle_acc_out", 32'(acc_out), 32'h0);
        check("idle_busy",    32'(busy),    32'd0);

        // Plain add.
        for (int i = 0; i < 3; i++) begin beat_d[i] = 16'h1111; beat_s[i] = 1'b0; end
        dc = done_count;
        run_reduction(4'd3, 3, 1'b0, 16'h3333, 4'h0, cyc);
        check("add_cycles",     32'(cyc),              32'd5);
        check("add_done_count", 32'(done_count - dc),  32'd1);
        tick();
        check("hold_acc_out", 32'(acc_out), 32'h3333);

        // Per-lane saturation.
        beat_d[0] = 16'h7F18; beat_s[0] = 1'b0;
        beat_d[1] = 16'h1F17; beat_s[1] = 1'b0;
        run_reduction(4'd2, 2, 1'b0, 16'h7E2F, 4'b1000, cyc);

        // Negative clamp on subtract.
        beat_d[0] = 16'h8000; beat_s[0] = 1'b0;
        beat_d[1] = 16'h1000; beat_s[1] = 1'b1;
        run_reduction(4'd2, 2, 1'b0, 16'h8000, 4'b1000, cyc);

        // 0 - (-8) clamps to +7; flags from the previous run must be cleared.
        beat_d[0] = 16'h0008; beat_s[0] = 1'b1;
        run_reduction(4'd1, 1, 1'b0, 16'h0007, 4'b0001, cyc);

        // Stalls plus start while busy.
        beat_d[0] = 16'h1111; beat_s[0] = 1'b0;
        beat_d[1] = 16'h0001; beat_s[1] = 1'b0;
        beat_d[2] = 16'h1000; beat_s[2] = 1'b0;
        beat_d[3] = 16'h0110; beat_s[3] = 1'b0;
        dc = done_count;
        run_reduction(4'd4, 4, 1'b1, 16'h2222, 4'h0, cyc);
        check("stall_cycles",     32'(cyc),             32'd8);
        check("stall_done_count", 32'(done_count - dc), 32'd1);

        // Abort after two beats with a concurrent third beat.
        dc    = done_count;
        start = 1'b1;
        len   = 4'd4;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sub   = 1'b0;
        bus.in_data  = 16'h1111; tick();
        bus.in_data  = 16'h2222; tick();
        bus.in_data  = 16'h1111;
        abort        = 1'b1;
        tick();
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_busy",    32'(busy),         32'd0);
        check("abort_acc_out", 32'(acc_out),      32'h3333);
        check("abort_ready",   32'(bus.in_ready), 32'd0);
        tick();
        check("abort_no_done", 32'(done_count - dc), 32'd0);

        // Abort in IDLE suppresses a concurrent start.
        start = 1'b1;
        len   = 4'd2;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_idle_busy", 32'(busy), 32'd0);

        // len = 0: done in the cycle right after start.
        start = 1'b1;
        len   = 4'd0;
        sb_q.push_back({16'h0000, 4'h0});
        tick();
        start = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        tick();
        check("len0_busy", 32'(busy), 32'd0);

        // len = 15 of 16'h1111: every lane saturates.
        for (int i = 0; i < 15; i++) begin beat_d[i] = 16'h1111; beat_s[i] = 1'b0; end
        run_reduction(4'd15, 15, 1'b0, 16'h7777, 4'hF, cyc);
        check("len15_cycles", 32'(cyc), 32'd17);

        // Reset mid-operation.
        dc    = done_count;
        start = 1'b1;
        len   = 4'd3;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h2222;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_acc_out",   32'(acc_out),   32'h0);
        check("midrst_sat_flags", 32'(sat_flags), 32'h0);
        repeat (3) tick();
        check("midrst_no_done",   32'(done_count - dc), 32'd0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
